// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/result handshake bundle between the core and the multiply/divide unit
interface alu_mdu_if #(parameter int XLEN = 32);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            i_flush;
  logic            o_valid;
  logic            i_res_ready;
  logic [XLEN-1:0] o_result;
  modport master (
    output i_valid, i_op, operand_a, operand_b, i_flush, i_res_ready,
    input  o_ready, o_valid, o_result
  );
  modport slave (
    input  i_valid, i_op, operand_a, operand_b, i_flush, i_res_ready,
    output o_ready, o_valid, o_result
  );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: iterative RV32M/RV64M multiply/divide, one result bit per cycle, magnitude datapath with final sign fix
module alu_mdu #(
  parameter int XLEN = 32
) (
  input logic      i_clk,
  input logic      i_rst_n,
  alu_mdu_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              a_s, b_s, a_neg, b_neg, div0, ovf, spec;
  logic [XLEN-1:0]   a_mag, b_mag, spec_res;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] mul_nx, div_nx, acc_nx, prod_s;
  logic [XLEN-1:0]   q_nx, r_nx, mul_res, div_res, fin;
  assign a_s      = ~(bus.i_op[0] & (bus.i_op[1] | bus.i_op[2]));
  assign b_s      = a_s & (bus.i_op != 3'b010);
  assign a_neg    = a_s & bus.operand_a[XLEN-1];
  assign b_neg    = b_s & bus.operand_b[XLEN-1];
  assign a_mag    = a_neg ? -bus.operand_a : bus.operand_a;
  assign b_mag    = b_neg ? -bus.operand_b : bus.operand_b;
  assign div0     = bus.i_op[2] & (bus.operand_b == '0);
  assign ovf      = bus.i_op[2] & ~bus.i_op[0] & (bus.operand_a == MIN_NEG) & (bus.operand_b == '1);
  assign spec     = div0 | ovf;
  assign spec_res = div0 ? (bus.i_op[1] ? bus.operand_a : '1) : (bus.i_op[1] ? '0 : MIN_NEG);
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_q[0]}} & m_q};
  assign mul_nx   = {mul_sum, acc_q[XLEN-1:1]};
  assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_sh - {1'b0, m_q};
  assign div_nx   = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign acc_nx   = op_q[2] ? div_nx : mul_nx;
  assign prod_s   = neg_q ? -acc_nx : acc_nx;
  assign q_nx     = acc_nx[XLEN-1:0];
  assign r_nx     = acc_nx[2*XLEN-1:XLEN];
  assign mul_res  = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  assign div_res  = op_q[1] ? (neg_q ? -r_nx : r_nx) : (neg_q ? -q_nx : q_nx);
  assign fin      = op_q[2] ? div_res : mul_res;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    m_d      = m_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (state_q == IDLE) begin
      if (bus.i_valid && !bus.i_flush) begin
        op_d     = bus.i_op;
        neg_d    = (bus.i_op[2] & bus.i_op[1]) ? a_neg : a_neg ^ b_neg;
        m_d      = bus.i_op[2] ? b_mag : a_mag;
        acc_d    = {{XLEN{1'b0}}, bus.i_op[2] ? a_mag : b_mag};
        cnt_d    = spec ? '0 : CNT_W'(XLEN);
        result_d = spec ? spec_res : result_q;
        state_d  = spec ? DONE : CALC;
      end
    end else if (bus.i_flush) begin
      state_d = IDLE;
    end else if (state_q == CALC) begin
      acc_d    = acc_nx;
      cnt_d    = cnt_q - CNT_W'(1);
      result_d = (cnt_q == CNT_W'(1)) ? fin : result_q;
      state_d  = (cnt_q == CNT_W'(1)) ? DONE : CALC;
    end else if (bus.i_res_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end
  assign bus.o_ready  = (state_q == IDLE);
  assign bus.o_valid  = (state_q == DONE);
  assign bus.o_result = result_q;
endmodule
